// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the DataMemory arbiter.
// Consumed by dmem_arbiter and arb_sat_counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LOCK_M0 = 2'd1,
    LOCK_M1 = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    M0   = 2'd0,
    M1   = 2'd1,
    NONE = 2'd2
  } master_t;

  localparam int unsigned STARVE_MAX_DEF = 8;
  localparam int unsigned LOCK_MAX_DEF   = 16;

  // Bits needed to hold the values 0..max inclusive (max >= 1).
  function automatic int unsigned cnt_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear; clear and increment together load 1.
// Used by dmem_arbiter for the burst-lock and starvation counts.
module arb_sat_counter
  import dmem_arb_pkg::*;
#(
  parameter  int unsigned MAX = 8,
  localparam int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == MaxVal);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port DataMemory (M0 = CPU, M1 = loader/debug DMA).
// Optional build macro DMEM_ARB_RR_EN selects round-robin instead of fixed M0 > M1 priority.
//
//   state   | meaning
//   FREE    | no burst owner; winner chosen by priority / starvation guard
//   LOCK_M0 | M0 holds a burst lock; M1 denied
//   LOCK_M1 | M1 holds a burst lock; M0 denied
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          m0_req_i,
  input  logic          m0_we_i,
  input  logic          m0_lock_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_we_i,
  input  logic          m1_lock_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wd_o,
  input  logic [DW-1:0] mem_rd_i
);

  localparam int unsigned LW = cnt_width(LOCK_MAX);
  localparam int unsigned SW = cnt_width(STARVE_MAX);
  localparam logic [LW-1:0] LockLast = LW'(LOCK_MAX - 1);

  arb_state_t state_q, state_d;
  master_t    win, rr_pick;

  logic          lock_inc, lock_clr, lock_at_max, lock_last;
  logic [LW-1:0] lock_cnt;
  logic          starve_inc, starve_clr, starve_at_max;
  logic [SW-1:0] starve_cnt_unused;

  logic          m0_rvalid_q, m1_rvalid_q;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  // The granted cycle that brings the count to LOCK_MAX is the last of the burst.
  assign lock_last = (lock_cnt == LockLast) || lock_at_max;

`ifdef DMEM_ARB_RR_EN
  master_t last_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q <= M1;
    end else if (m0_gnt_o) begin
      last_q <= M0;
    end else if (m1_gnt_o) begin
      last_q <= M1;
    end
  end

  assign rr_pick = (last_q == M0) ? M1 : M0;
`else
  assign rr_pick = M0;
`endif

  always_comb begin
    state_d  = state_q;
    win      = NONE;
    lock_inc = 1'b0;
    lock_clr = 1'b0;
    unique case (state_q)
      FREE: begin
        lock_clr = 1'b1;
        if (m1_req_i && starve_at_max)   win = M1;
        else if (m0_req_i && m1_req_i)   win = rr_pick;
        else if (m0_req_i)               win = M0;
        else if (m1_req_i)               win = M1;
        if ((win == M0) && m0_lock_i) begin
          state_d  = LOCK_M0;
          lock_inc = 1'b1;
        end else if ((win == M1) && m1_lock_i) begin
          state_d  = LOCK_M1;
          lock_inc = 1'b1;
        end
      end
      LOCK_M0: begin
        if (!m0_req_i) begin
          state_d = FREE;
        end else begin
          win      = M0;
          lock_inc = 1'b1;
          if (!m0_lock_i || lock_last) state_d = FREE;
        end
      end
      LOCK_M1: begin
        if (!m1_req_i) begin
          state_d = FREE;
        end else begin
          win      = M1;
          lock_inc = 1'b1;
          if (!m1_lock_i || lock_last) state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants are suppressed combinationally while reset is held.
  assign m0_gnt_o = reset_ni && (win == M0);
  assign m1_gnt_o = reset_ni && (win == M1);

  assign mem_we_o   = (m0_gnt_o && m0_we_i) || (m1_gnt_o && m1_we_i);
  assign mem_addr_o = m1_gnt_o ? m1_addr_i  : m0_addr_i;
  assign mem_wd_o   = m1_gnt_o ? m1_wdata_i : m0_wdata_i;

  assign starve_inc = m1_req_i && !m1_gnt_o;
  assign starve_clr = !m1_req_i || m1_gnt_o;

  arb_sat_counter #(.MAX(LOCK_MAX)) u_lock_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc_i    (lock_inc),
    .clr_i    (lock_clr),
    .cnt_o    (lock_cnt),
    .at_max_o (lock_at_max)
  );

  arb_sat_counter #(.MAX(STARVE_MAX)) u_starve_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .cnt_o    (starve_cnt_unused),
    .at_max_o (starve_at_max)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_gnt_o && !m0_we_i;
      m1_rvalid_q <= m1_gnt_o && !m1_we_i;
      if (m0_gnt_o && !m0_we_i) m0_rdata_q <= mem_rd_i;
      if (m1_gnt_o && !m1_we_i) m1_rdata_q <= mem_rd_i;
    end
  end

  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule
